d_ext_arbiter: RTL and testbench

//   Shares the single decode-stage immediate extender between two requesters
//   (port 0: D-stage instruction decode, port 1: CP0/exception address path).

---
 rtl/d_ext_arbiter.sv | 95 +++++++++
 tb/tb_d_ext_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/d_ext_arbiter.sv
// Two-requester round-robin front end for the shared decode-stage immediate extender.
// Drives the extender combinationally from the granted request and registers its result in a one-entry slot.
module d_ext_arbiter #(
  parameter int IMM_W = 16,
  parameter int DAT_W = 32,
  parameter int OP_W  = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IMM_W-1:0] req0_imm,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IMM_W-1:0] req1_imm,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [IMM_W-1:0] ext_in,
  output logic [OP_W-1:0]  ext_op,
  input  logic [DAT_W-1:0] ext_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DAT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src
);

  logic             r_rr_ptr;
  logic             r_out_valid;
  logic [DAT_W-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_src;

  logic             w_slot_free;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer;
  logic [OP_W-1:0]  w_op_sel;
  logic [TAG_W-1:0] w_tag_sel;

  // Slot accepts a new result when empty or being drained this same cycle.
  assign w_slot_free = !r_out_valid || out_ready;

  assign w_gnt0 = w_slot_free && req0_valid && (!req1_valid || !r_rr_ptr);
  assign w_gnt1 = w_slot_free && req1_valid && (!req0_valid ||  r_rr_ptr);
  assign w_xfer = w_gnt0 || w_gnt1;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    ext_in    = '0;
    w_op_sel  = '0;
    w_tag_sel = '0;
    if (w_gnt0) begin
      ext_in    = req0_imm;
      w_op_sel  = req0_op;
      w_tag_sel = req0_tag;
    end else if (w_gnt1) begin
      ext_in    = req1_imm;
      w_op_sel  = req1_op;
      w_tag_sel = req1_tag;
    end
  end

  // Reserved mode (all ones) falls back to sign extension.
  assign ext_op = (w_op_sel == {OP_W{1'b1}}) ? OP_W'(1) : w_op_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_src   <= 1'b0;
    end else if (w_xfer) begin
      r_rr_ptr    <= ~w_gnt1;
      r_out_valid <= 1'b1;
      r_out_data  <= ext_res;
      r_out_tag   <= w_tag_sel;
      r_out_src   <= w_gnt1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_d_ext_arbiter.sv
// Directed bench for d_ext_arbiter: a reference extender drives ext_res, a behavioural
// slot/arbiter model is checked every negedge, and literal expectations pin key cycles.
module tb_d_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_imm, req1_imm;
  logic [1:0]  req0_op, req1_op;
  logic [3:0]  req0_tag, req1_tag;
  logic [15:0] ext_in;
  logic [1:0]  ext_op;
  logic [31:0] ext_res;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_src;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_ext_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_imm   (req0_imm),
    .req0_op    (req0_op),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_imm   (req1_imm),
    .req1_op    (req1_op),
    .req1_tag   (req1_tag),
    .ext_in     (ext_in),
    .ext_op     (ext_op),
    .ext_res    (ext_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_src    (out_src)
  );

  // Stand-in for the shared extender: only modes 0..2 are legal on its input.
  function automatic logic [31:0] extender(input logic [15:0] i, input logic [1:0] o);
    case (o)
      2'b00:   return {16'h0000, i};
      2'b01:   return {{16{i[15]}}, i};
      2'b10:   return {i, 16'h0000};
      default: return 32'hDEADBEEF;
    endcase
  endfunction
  assign ext_res = extender(ext_in, ext_op);

  // What a request must produce, stated arithmetically.
  function automatic logic [31:0] expect_ext(input logic [15:0] i, input logic [1:0] o);
    int v;
    if (o == 2'b10) return 32'(i) * 65536;
    v = int'(i);
    if (o != 2'b00 && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [3:0]  m_tag   = '0;
  logic        m_src   = 1'b0;
  int          m_next  = 0;   // requester that wins a tie
  int          m_win;
  logic [15:0] m_imm;
  logic [1:0]  m_op;
  logic [3:0]  m_tg;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_valid = 1'b0; m_data = '0; m_tag = '0; m_src = 1'b0; m_next = 0;
      chk("m_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("m_rst_data", out_data, 32'd0);
      chk("m_rst_tag", {28'b0, out_tag}, 32'd0);
      chk("m_rst_src", {31'b0, out_src}, 32'd0);
    end else begin
      m_win = -1;
      if (!(m_valid && !out_ready)) begin
        if (req0_valid && req1_valid) m_win = m_next;
        else if (req0_valid)          m_win = 0;
        else if (req1_valid)          m_win = 1;
      end
      m_imm = 16'h0; m_op = 2'b00; m_tg = 4'h0;
      if (m_win == 0) begin m_imm = req0_imm; m_op = req0_op; m_tg = req0_tag; end
      if (m_win == 1) begin m_imm = req1_imm; m_op = req1_op; m_tg = req1_tag; end
      chk("m_ready0", {31'b0, req0_ready}, (m_win == 0) ? 32'd1 : 32'd0);
      chk("m_ready1", {31'b0, req1_ready}, (m_win == 1) ? 32'd1 : 32'd0);
      chk("m_ext_in", {16'b0, ext_in}, {16'b0, m_imm});
      chk("m_ext_op", {30'b0, ext_op}, (m_op == 2'b11) ? 32'd1 : {30'b0, m_op});
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("m_out_data", out_data, m_data);
      chk("m_out_tag", {28'b0, out_tag}, {28'b0, m_tag});
      chk("m_out_src", {31'b0, out_src}, {31'b0, m_src});
      if (m_win >= 0) begin
        m_valid = 1'b1;
        m_data  = expect_ext(m_imm, m_op);
        m_tag   = m_tg;
        m_src   = (m_win == 1);
        m_next  = 1 - m_win;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_imm = '0; req0_op = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_imm = '0; req1_op = '0; req1_tag = '0;
    repeat (3) cyc;
    chk("init_valid", {31'b0, out_valid}, 32'd0);
    chk("init_data", out_data, 32'd0);

    // Reset while slot full and both requesting.
    reset_n = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b1; req0_imm = 16'h1111; req0_op = 2'b00; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_imm = 16'h2222; req1_op = 2'b00; req1_tag = 4'd2;
    #1;
    chk("t1_first_ready0", {31'b0, req0_ready}, 32'd1);
    cyc;
    chk("t1_fill_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_fill_data", out_data, 32'h00001111);
    req0_valid = 1'b0;
    cyc;
    reset_n = 1'b0;
    #1;
    chk("t1_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t1_rst_data", out_data, 32'd0);
    cyc;
    reset_n = 1'b1; out_ready = 1'b1; req0_valid = 1'b1;
    #1;
    chk("t1_post_rst_ready0", {31'b0, req0_ready}, 32'd1);
    chk("t1_post_rst_ready1", {31'b0, req1_ready}, 32'd0);
    cyc;
    chk("t1_post_rst_src", {31'b0, out_src}, 32'd0);

    // Sign extension, single requester, 1-cycle latency.
    req1_valid = 1'b0;
    req0_imm = 16'h8001; req0_op = 2'b01; req0_tag = 4'd3;
    #1;
    chk("t2_ready0", {31'b0, req0_ready}, 32'd1);
    cyc;
    chk("t2_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_data", out_data, 32'hFFFF8001);
    chk("t2_tag", {28'b0, out_tag}, 32'd3);
    chk("t2_src", {31'b0, out_src}, 32'd0);

    // Stall for three cycles, then accept on release.
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_imm = 16'h00AA; req0_op = 2'b00; req0_tag = 4'd5;
    req1_valid = 1'b1; req1_imm = 16'h7FFF; req1_op = 2'b01; req1_tag = 4'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_ready0", {31'b0, req0_ready}, 32'd0);
      chk("t4_stall_ready1", {31'b0, req1_ready}, 32'd0);
      cyc;
      chk("t4_stall_data", out_data, 32'hFFFF8001);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_release_ready1", {31'b0, req1_ready}, 32'd1);
    cyc;
    chk("t4_release_data", out_data, 32'h00007FFF);
    chk("t4_release_tag", {28'b0, out_tag}, 32'd6);

    // Back-to-back alternation.
    for (int i = 0; i < 6; i++) begin
      cyc;
      chk("t3_src", {31'b0, out_src}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("t3_valid", {31'b0, out_valid}, 32'd1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc;
    chk("t3_drain_valid", {31'b0, out_valid}, 32'd0);
    chk("t3_drain_src_hold", {31'b0, out_src}, 32'd1);
    chk("t3_drain_data_hold", out_data, 32'h00007FFF);

    // Extension modes, including reserved op remap.
    req0_valid = 1'b1; req0_imm = 16'h8000; req0_op = 2'b00; req0_tag = 4'd7;
    cyc;
    chk("t5_zero", out_data, 32'h00008000);
    req0_op = 2'b11;
    #1;
    chk("t5_remap_op", {30'b0, ext_op}, 32'd1);
    cyc;
    chk("t5_rsvd_sign", out_data, 32'hFFFF8000);
    req0_imm = 16'h1234; req0_op = 2'b10;
    cyc;
    chk("t5_upper", out_data, 32'h12340000);

    // Lone requester 1 wins regardless of pointer; pointer then favours 0.
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_imm = 16'h0042; req1_op = 2'b00; req1_tag = 4'd9;
    cyc;
    req1_imm = 16'h0043; req1_tag = 4'd10;
    #1;
    chk("t6_ready1", {31'b0, req1_ready}, 32'd1);
    cyc;
    chk("t6_src", {31'b0, out_src}, 32'd1);
    chk("t6_data", out_data, 32'h00000043);
    req0_valid = 1'b1;
    #1;
    chk("t6_ptr_ready0", {31'b0, req0_ready}, 32'd1);
    chk("t6_ptr_ready1", {31'b0, req1_ready}, 32'd0);
    cyc;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) cyc;
    chk("idle_ext_in", {16'b0, ext_in}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
